// File: rtl/adc_overload_detector.sv
// ADC overload detector: two-stage pipeline that turns the sample stream into
// per-window hit counts, a rail flag and the window peak magnitude.
module adc_overload_detector #(
  parameter int WINDOW_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   sample_valid,
  input  logic [15:0]            sample,
  input  logic [14:0]            threshold,
  input  logic [WINDOW_LOG2:0]   min_hits,
  input  logic                   clear,
  output logic                   overload,
  output logic [14:0]            peak_mag,
  output logic                   window_done
);

  localparam logic [WINDOW_LOG2-1:0] SCNT_LAST = '1;
  localparam logic [14:0]            MAG_RAIL  = 15'h7fff;

  logic [15:0]            abs_full;
  logic [14:0]            mag_in;
  logic                   v1;
  logic [14:0]            mag1;
  logic [WINDOW_LOG2-1:0] scnt;
  logic [WINDOW_LOG2:0]   hits;
  logic [14:0]            pk;
  logic                   rail_seen;

  logic                   hit;
  logic                   rail;
  logic [WINDOW_LOG2:0]   hits_incl;
  logic [14:0]            pk_incl;
  logic                   rail_incl;
  logic                   window_end;
  logic                   count_overload;

  // Magnitude of the incoming sample; -32768 has no positive twin so it pins to the rail.
  always_comb begin
    abs_full = sample[15] ? (~sample + 16'd1) : sample;
    mag_in   = abs_full[15] ? MAG_RAIL : abs_full[14:0];
  end

  always_comb begin
    hit            = (mag1 >= threshold);
    rail           = (mag1 == MAG_RAIL);
    hits_incl      = hits + {{WINDOW_LOG2{1'b0}}, hit};
    pk_incl        = (mag1 > pk) ? mag1 : pk;
    rail_incl      = rail_seen | rail;
    window_end     = v1 && (scnt == SCNT_LAST);
    count_overload = (min_hits != '0) && (hits_incl >= min_hits);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      v1   <= 1'b0;
      mag1 <= '0;
    end else if (clear) begin
      v1   <= 1'b0;
      mag1 <= '0;
    end else begin
      v1 <= sample_valid;
      if (sample_valid)
        mag1 <= mag_in;
    end
  end

  // Window accumulation; the window-end branch folds in the current sample and restarts.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      scnt        <= '0;
      hits        <= '0;
      pk          <= '0;
      rail_seen   <= 1'b0;
      overload    <= 1'b0;
      peak_mag    <= '0;
      window_done <= 1'b0;
    end else if (clear) begin
      scnt        <= '0;
      hits        <= '0;
      pk          <= '0;
      rail_seen   <= 1'b0;
      overload    <= 1'b0;
      peak_mag    <= '0;
      window_done <= 1'b0;
    end else if (window_end) begin
      scnt        <= '0;
      hits        <= '0;
      pk          <= '0;
      rail_seen   <= 1'b0;
      overload    <= count_overload || rail_incl;
      peak_mag    <= pk_incl;
      window_done <= 1'b1;
    end else begin
      window_done <= 1'b0;
      if (v1) begin
        scnt      <= scnt + 1'b1;
        hits      <= hits_incl;
        pk        <= pk_incl;
        rail_seen <= rail_incl;
        if (rail)
          overload <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_overload_detector.sv
// Randomized scoreboard bench for adc_overload_detector: a window-level model
// predicts each window result, a monitor checks it when window_done fires.
module tb_adc_overload_detector;

  localparam int W   = 5;
  localparam int WIN = 1 << W;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample = '0;
  logic [14:0] threshold = '0;
  logic [W:0]  min_hits = '0;
  logic        clear = 1'b0;
  logic        overload;
  logic [14:0] peak_mag;
  logic        window_done;

  typedef struct {
    bit     ovl;
    int     peak;
    longint due;
  } exp_t;

  exp_t   exp_q[$];
  int     win_q[$];
  longint cyc = 0;
  int     n_compared = 0;
  int     n_mismatched = 0;

  adc_overload_detector #(.WINDOW_LOG2(W)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .threshold    (threshold),
    .min_hits     (min_hits),
    .clear        (clear),
    .overload     (overload),
    .peak_mag     (peak_mag),
    .window_done  (window_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mag_of(input logic [15:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Window result straight from the rules: count hits, look for the rail, take the max.
  task automatic close_window();
    exp_t e;
    int   nhits;
    int   pk;
    bit   rail;
    nhits = 0;
    pk    = 0;
    rail  = 1'b0;
    foreach (win_q[i]) begin
      if (win_q[i] >= int'(threshold)) nhits++;
      if (win_q[i] > pk) pk = win_q[i];
      if (win_q[i] == 32767) rail = 1'b1;
    end
    e.ovl  = ((min_hits != 0) && (nhits >= int'(min_hits))) || rail;
    e.peak = pk;
    e.due  = cyc + 2;
    exp_q.push_back(e);
    win_q.delete();
  endtask

  task automatic apply_stimulus(input bit valid, input int value, input bit clr);
    @(negedge clk);
    sample_valid = valid;
    sample       = value[15:0];
    clear        = clr;
    if (clr) begin
      win_q.delete();
    end else if (valid) begin
      win_q.push_back(mag_of(value[15:0]));
      if (win_q.size() == WIN) close_window();
    end
  endtask

  task automatic set_cfg(input int thr, input int mh);
    apply_stimulus(1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0);
    threshold = thr[14:0];
    min_hits  = mh[W:0];
  endtask

  function automatic int rand_sample();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    if (r < 8)  return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (n_reset && window_done) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_window_done: got 1, expected 0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check_output("window_overload", longint'(overload), longint'(e.ovl));
        check_output("window_peak", longint'(peak_mag), longint'(e.peak));
        check_output("window_done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    int cnt;
    int thr;
    int mh;
    int pos[4];

    #1 n_reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_overload", longint'(overload), 0);
    check_output("reset_peak", longint'(peak_mag), 0);
    check_output("reset_window_done", longint'(window_done), 0);
    n_reset = 1'b1;

    $display("[TB] constant +100 window");
    set_cfg(1000, 4);
    for (int i = 0; i < WIN; i++) apply_stimulus(1'b1, 100, 1'b0);

    $display("[TB] four -2000 hits among +10");
    set_cfg(2000, 4);
    for (int k = 0; k < 4; k++) pos[k] = k * 8 + int'($urandom_range(0, 7));
    for (int i = 0; i < WIN; i++)
      apply_stimulus(1'b1, (i == pos[0] || i == pos[1] || i == pos[2] || i == pos[3]) ? -2000 : 10, 1'b0);
    for (int i = 0; i < WIN; i++) apply_stimulus(1'b1, 10, 1'b0);

    $display("[TB] early rail");
    set_cfg(1000, 0);
    for (int i = 0; i < WIN; i++) begin
      if (i == 4) check_output("pre_rail_overload", longint'(overload), 0);
      if (i == 7) check_output("early_rail_overload", longint'(overload), 1);
      apply_stimulus(1'b1, (i == 4) ? -32768 : 10, 1'b0);
    end

    $display("[TB] valid gaps");
    set_cfg(500, 8);
    for (int i = 0; i < WIN; i++) begin
      apply_stimulus(1'b1, int'($urandom_range(0, 2000)) - 1000, 1'b0);
      apply_stimulus(1'b0, int'($urandom_range(0, 65535)), 1'b0);
    end

    $display("[TB] clear mid-window");
    set_cfg(1000, 4);
    for (int i = 0; i < 19; i++) apply_stimulus(1'b1, (i < 10) ? 2000 : 5, 1'b0);
    apply_stimulus(1'b1, 3000, 1'b1);
    apply_stimulus(1'b0, 0, 1'b0);
    check_output("clear_overload", longint'(overload), 0);
    check_output("clear_peak", longint'(peak_mag), 0);
    check_output("clear_window_done", longint'(window_done), 0);
    for (int i = 0; i < WIN; i++) apply_stimulus(1'b1, (i < 3) ? 2000 : 5, 1'b0);

    $display("[TB] random windows");
    for (int w = 0; w < 10; w++) begin
      case ($urandom_range(0, 3))
        0:       thr = 0;
        1:       thr = 32767;
        default: thr = int'($urandom_range(0, 32767));
      endcase
      case ($urandom_range(0, 3))
        0:       mh = 0;
        1:       mh = int'($urandom_range(WIN + 1, 2 * WIN - 1));
        default: mh = int'($urandom_range(1, WIN));
      endcase
      set_cfg(thr, mh);
      cnt = 0;
      while (cnt < WIN) begin
        if ($urandom_range(0, 3) == 0) begin
          apply_stimulus(1'b0, rand_sample(), 1'b0);
        end else begin
          apply_stimulus(1'b1, rand_sample(), 1'b0);
          cnt++;
        end
      end
    end

    $display("[TB] async reset mid-window");
    set_cfg(1000, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, (i == 2) ? -32768 : 50, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0);
    check_output("pre_reset_overload", longint'(overload), 1);
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    check_output("async_reset_overload", longint'(overload), 0);
    check_output("async_reset_peak", longint'(peak_mag), 0);
    check_output("async_reset_window_done", longint'(window_done), 0);
    win_q.delete();
    @(negedge clk);
    n_reset = 1'b1;
    set_cfg(1500, 3);
    for (int i = 0; i < WIN; i++) apply_stimulus(1'b1, int'($urandom_range(0, 4000)) - 2000, 1'b0);

    repeat (6) apply_stimulus(1'b0, 0, 1'b0);
    check_output("pending_windows", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/adc_overload_detector.md
# adc_overload_detector

Upstream conditioning stage for the AGC. Watches the ADC sample stream and produces the one-bit `overload` the AGC controller OR-accumulates into its indicator during detection. Saturation is decided per fixed window of valid samples: a hit count against a programmable threshold, plus an immediate rail flag. The block also reports the window peak magnitude for debug.

## Interface
- `WINDOW_LOG2`, default 5: window length is 2^WINDOW_LOG2 valid samples (32).
- `clk`  in  1: sample clock, all logic on rising edge.
- `n_reset`  in  1: asynchronous, active-low reset.
- `sample_valid`  in  1: `sample` is valid this cycle.
- `sample`  in  16: ADC output, signed two's complement.
- `threshold`  in  15: unsigned magnitude threshold; a hit is magnitude >= threshold. Quasi-static.
- `min_hits`  in  WINDOW_LOG2+1: hits per window needed to flag overload. Quasi-static.
- `clear`  in  1: synchronous clear of all window state.
- `overload`  out  1: registered level, updated at window end, set early on rail.
- `peak_mag`  out  15: maximum magnitude of the last completed window.
- `window_done`  out  1: one-cycle pulse when a window completes.

## Operation
- Stage 1 (magnitude), on a valid sample:
  - `mag1 = |sample|`.
  - -32768 saturates to 32767, so the result is always 15 bits.
  - Latch `v1 = sample_valid`.
- Stage 2 (window), when `v1`:
  - `hit = (mag1 >= threshold)`; `rail = (mag1 == 32767)`.
  - `hits` (WINDOW_LOG2+1 bits) increments on hit. It cannot overflow because the window holds at most 2^WINDOW_LOG2 samples.
  - `pk` tracks the running maximum of `mag1`.
  - `rail_seen` is set on rail.
  - `scnt` (WINDOW_LOG2 bits) counts valid samples 0..2^W-1 and wraps.
- Window end (`v1` and `scnt == 2^W-1`), using values that include the current sample:
  - `overload <= ((min_hits != 0) && (hits_incl >= min_hits)) || rail_seen_incl`.
  - `peak_mag <= pk_incl`; `window_done <= 1`.
  - `hits`, `pk` and `rail_seen` restart at 0, so the next window starts fresh.
- Early rail: when `rail` is true mid-window, `overload <= 1` on the same edge. It stays high at least until the next window-end evaluation.
- Otherwise `overload` and `peak_mag` hold; `window_done <= 0`.
- Boundary rules:
  - `min_hits == 0`: only rail can assert `overload`.
  - `threshold == 0`: every valid sample hits.
  - `min_hits > 2^W`: unreachable by hit count; only rail can assert.
- `clear`:
  - Zeroes `v1`, `scnt`, `hits`, `pk`, `rail_seen`, `overload`, `peak_mag` and `window_done`.
  - Takes priority over `sample_valid` and over any window end in the same cycle.
  - The sample present during `clear` is discarded.
- Gaps in `sample_valid` stall the window; no timeout.

## Timing
- Reset values (async on `n_reset` low): `overload=0`, `peak_mag=0`, `window_done=0`; `v1`, `scnt`, `hits`, `pk` and `rail_seen` are also 0.
- Latency from the edge capturing sample k into stage 1:
  - `overload`, `peak_mag` and `window_done` reflect sample k one edge later (2 edges from input to output).
- Window j ends on the 2^W-th valid sample after reset/clear or after the previous window end.
- `window_done` is high for exactly one cycle per window.
- Back-to-back windows with continuous valid have no dead cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then 32 valid samples of +100 with `threshold=1000`, `min_hits=4`:
  - `window_done` pulses 2 cycles after the 32nd sample.
  - `overload=0`, `peak_mag=100`.
- Window with exactly 4 samples of -2000 among +10s, `threshold=2000`, `min_hits=4`:
  - `overload=1` at window end, `peak_mag=2000`.
  - Next window of all +10 returns `overload=0`.
- Sample -32768 at position 5, `min_hits=0`:
  - `overload=1` two edges after that sample, before the window ends.
  - Stays 1 at window end; `peak_mag=32767`.
- `sample_valid` toggling every other cycle:
  - The window closes only after 32 valid samples (about 64 cycles); hit count is unaffected by gaps.
- `clear` asserted with `sample_valid` on the 20th sample of a window holding 10 hits:
  - All outputs 0 next cycle.
  - The following window counts from 0, and the discarded sample does not contribute.
- `n_reset` pulsed low mid-window with `overload=1`:
  - Outputs go 0 immediately (asynchronous), not waiting for a clock edge.
  - Operation resumes with a fresh window after release.
